ddr_rd_responder: RTL and testbench
===================================

DDR_RD_RESPONDER -- requirements
Module: ddr_rd_responder

Interface
REQ-001 Parameter REQ_DEPTH, default 4, SHALL set the request FIFO depth in entries (power of two, at least 2).
REQ-002 Parameter MEM_LAT, default 2, SHALL set the fixed backing-memory read latency in cycles (at least 1).
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous assert, active-low (0 = reset).
REQ-005 ddr_addr  in  DDR_ADDR_W  SHALL carry the burst start word address.
REQ-006 ddr_size  in  BURST_W  SHALL carry the burst length in beats.
REQ-007 ddr_addr_valid  in  1  SHALL mark a request present; ddr_addr_ready  out  1  SHALL mark that the request can be accepted.
REQ-008 ddr_data  out  DDR_W  SHALL carry the read beat; ddr_valid  out  1  SHALL mark it valid; ddr_ready  in  1  SHALL be the consumer accept.
REQ-009 ddr_last  out  1  SHALL mark the final beat of a burst.
REQ-010 mem_rd_en  out  1 and mem_rd_addr  out  DDR_ADDR_W SHALL form the backing-memory read port; mem_rd_data  in  DDR_W SHALL return data exactly MEM_LAT cycles after mem_rd_en.

Function
REQ-011 A request SHALL be accepted on a cycle where ddr_addr_valid and ddr_addr_ready are both 1; ddr_addr_ready SHALL be 1 exactly when the request FIFO is not full, with no combinational dependence on ddr_addr_valid.
REQ-012 When the FIFO is full, an accept and a pop in the same cycle SHALL NOT happen, because ready is 0 and there is no pass-through.
REQ-013 The FSM SHALL have two states, IDLE and BURST; it SHALL reset to IDLE.
REQ-014 In IDLE with the FIFO non-empty, the FSM SHALL pop one request. If size is 0 it SHALL discard the request, produce no beats and remain IDLE. Otherwise it SHALL load the address and beat counters and enter BURST.
REQ-015 In BURST, mem_rd_en SHALL assert on a cycle only if credit is available. Credit = OUT_DEPTH minus (reads in flight plus output FIFO occupancy), where OUT_DEPTH = MEM_LAT + 2.
REQ-016 Each issued read SHALL use mem_rd_addr = start + beat index modulo 2^DDR_ADDR_W (address wrap-around permitted); the counter SHALL decrement by 1 per issue.
REQ-017 The issue of the final beat SHALL return the FSM to IDLE, leaving one idle cycle before the next burst's first issue.
REQ-018 A MEM_LAT-deep valid/last shift pipeline SHALL write mem_rd_data and the last flag into the output FIFO, which SHALL never overflow.
REQ-019 ddr_valid SHALL be 1 whenever the output FIFO is non-empty; ddr_data and ddr_last SHALL hold stable while ddr_valid is 1 and ddr_ready is 0.
REQ-020 Beats SHALL be returned in request order and address order, with no gaps other than credit stalls or backpressure; peak throughput SHALL be one beat per cycle.
REQ-021 First-beat latency SHALL be: accept, then pop 1 cycle later, then issue 1 cycle later, then data in the output FIFO after MEM_LAT cycles, then ddr_valid the next cycle. This gives MEM_LAT+3 cycles from accept to ddr_valid with the path unstalled.
REQ-022 Simultaneous push and pop on the output FIFO SHALL keep occupancy unchanged.

Reset
REQ-023 Assertion of rst SHALL immediately force ddr_addr_ready=0, ddr_valid=0, ddr_last=0, mem_rd_en=0, mem_rd_addr=0, ddr_data=0, FSM=IDLE, and both FIFOs empty.
REQ-024 Reset asserted mid-burst SHALL discard all pending requests, in-flight reads and buffered beats; after release no stale beat SHALL be emitted.
REQ-025 ddr_addr_ready SHALL rise on the first clock edge after rst deasserts.

Structure
REQ-026 DDR_W, DDR_ADDR_W and BURST_W SHALL come from GLOBAL_PARAM; a request struct typedef (addr, size) and the FSM state enum SHALL be added to that package.
REQ-027 One sub-module, sync_fifo (parameterised width/depth, full/empty/count outputs), SHALL be instantiated twice: once for requests and once for output beats.

Verification
REQ-028 Single burst: addr=0x100, size=4, ddr_ready=1, MEM_LAT=2 -> beats from 0x100..0x103 in order, ddr_valid first high 5 cycles after accept, ddr_last only on beat 4.
REQ-029 Size 0: request addr=0x20, size=0, followed by addr=0x40, size=1 -> exactly one beat (0x40) with ddr_last=1.
REQ-030 Backpressure: size=8 with ddr_ready held 0 for 20 cycles -> at most 4 mem_rd_en pulses, output held stable, then all 8 beats in order with no loss or duplication.
REQ-031 FIFO full: 6 back-to-back requests of size=16 with ddr_ready=0 -> ddr_addr_ready=0 after 4 are buffered (1 popped, 4 held), and no request is lost.
REQ-032 Wrap: addr=2^DDR_ADDR_W-2, size=4 -> mem_rd_addr sequence max-1, max, 0, 1.
REQ-033 Mid-burst reset: rst low for 1 cycle during beat 3 of size=8 -> all outputs at reset values, and after release only beats of new requests appear.

Source files
------------

// File: rtl/ddr_rd_responder_pkg.sv
// ----------------------------------------------------------------------------
// ddr_rd_responder_pkg
// Global widths for the DDR read responder, plus the request record and the
// burst-sequencer state type shared by the top level and its bench.
//   DDR_W      : width of one read beat
//   DDR_ADDR_W : width of a word address (addresses wrap modulo 2^DDR_ADDR_W)
//   BURST_W    : width of the burst length field (beats)
// ----------------------------------------------------------------------------
package ddr_rd_responder_pkg;

  localparam int DDR_W      = 32;
  localparam int DDR_ADDR_W = 16;
  localparam int BURST_W    = 8;

  localparam int REQ_W = DDR_ADDR_W + BURST_W;

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
    logic [BURST_W-1:0]    size;
  } req_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/ddr_rd_responder_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered pointers and an occupancy counter.
// Depth need not be a power of two; pointers wrap explicitly at DEPTH-1.
// Push while full and pop while empty are ignored. A simultaneous push and
// pop leaves the occupancy unchanged. The head entry is visible on pop_data
// whenever the FIFO is non-empty (first-word fall-through).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   push, push_data     : write request and data
//   pop, pop_data       : read request and head data
//   full, empty, count  : status
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is data only: never reset, validity comes from count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_rd_responder.sv
// ----------------------------------------------------------------------------
// ddr_rd_responder
// Accepts burst read requests (start word address + beat count), buffers them
// in a request FIFO, and for each one issues sequential reads to a fixed
// latency backing memory. Returned words are collected in an output FIFO and
// presented as a valid/ready beat stream with a last-beat marker.
// Reads are only issued when the output FIFO is guaranteed room for the
// returning word, so the output FIFO can never overflow under backpressure.
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   ddr_addr, ddr_size                : request start address and beat count
//   ddr_addr_valid, ddr_addr_ready    : request handshake
//   ddr_data, ddr_last                : read beat and final-beat marker
//   ddr_valid, ddr_ready              : beat handshake
//   mem_rd_en, mem_rd_addr            : backing-memory read command
//   mem_rd_data                       : read data, MEM_LAT cycles after command
// ----------------------------------------------------------------------------
module ddr_rd_responder
  import ddr_rd_responder_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int MEM_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DDR_ADDR_W-1:0] ddr_addr,
  input  logic [BURST_W-1:0]    ddr_size,
  input  logic                  ddr_addr_valid,
  output logic                  ddr_addr_ready,
  output logic [DDR_W-1:0]      ddr_data,
  output logic                  ddr_valid,
  input  logic                  ddr_ready,
  output logic                  ddr_last,
  output logic                  mem_rd_en,
  output logic [DDR_ADDR_W-1:0] mem_rd_addr,
  input  logic [DDR_W-1:0]      mem_rd_data
);

  localparam int OUT_DEPTH = MEM_LAT + 2;
  localparam int OCW       = $clog2(OUT_DEPTH + 1);
  localparam int RCW       = $clog2(REQ_DEPTH + 1);

  // Request side
  req_t            req_in;
  req_t            req_head;
  logic            req_push;
  logic            req_pop;
  logic            req_full;
  logic            req_empty;
  logic [RCW-1:0]  unused_req_count;
  logic            ready_en;

  // Burst sequencer
  state_t                state;
  logic [DDR_ADDR_W-1:0] addr_cnt;
  logic [BURST_W-1:0]    beats_left;
  logic                  issue;
  logic                  issue_last;
  logic                  credit_ok;

  // Return path
  logic [MEM_LAT-1:0] vld_pipe;
  logic [MEM_LAT-1:0] last_pipe;
  logic [OCW-1:0]     inflight;
  logic [OCW-1:0]     out_count;
  logic [DDR_W:0]     out_head;
  logic               out_empty;
  logic               unused_out_full;

  function automatic logic [OCW-1:0] popcount(input logic [MEM_LAT-1:0] v);
    logic [OCW-1:0] c;
    c = '0;
    for (int i = 0; i < MEM_LAT; i++) c = c + OCW'(v[i]);
    return c;
  endfunction

  // ---- request acceptance ----
  // ready_en holds ready low throughout reset and releases it on the first
  // edge after reset deasserts; otherwise ready is simply "not full".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  assign ddr_addr_ready = ready_en && !req_full;
  assign req_push       = ddr_addr_valid && ddr_addr_ready;
  assign req_in         = '{addr: ddr_addr, size: ddr_size};

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_push),
    .push_data (req_in),
    .pop       (req_pop),
    .pop_data  (req_head),
    .full      (req_full),
    .empty     (req_empty),
    .count     (unused_req_count)
  );

  // ---- burst sequencer ----
  // Credit counts every word already committed to the output FIFO: reads still
  // in the memory pipeline plus words buffered. A read this cycle is allowed
  // only if its word is guaranteed a slot. Pops in the same cycle are not
  // credited, which costs nothing at full rate because OUT_DEPTH leaves one
  // slot of slack beyond the pipeline.
  assign inflight   = popcount(vld_pipe);
  assign credit_ok  = ({1'b0, inflight} + {1'b0, out_count}) < (OCW + 1)'(OUT_DEPTH);
  assign req_pop    = (state == ST_IDLE) && !req_empty;
  assign issue      = (state == ST_BURST) && credit_ok;
  assign issue_last = (beats_left == BURST_W'(1));

  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      addr_cnt   <= '0;
      beats_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A zero-length request is popped and dropped without a burst.
          if (req_pop && (req_head.size != '0)) begin
            addr_cnt   <= req_head.addr;
            beats_left <= req_head.size;
            state      <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (issue) begin
            addr_cnt   <= addr_cnt + DDR_ADDR_W'(1);
            beats_left <= beats_left - BURST_W'(1);
            if (issue_last) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- memory latency pipeline ----
  // Tracks which cycles carry returning data and whether each is a burst end;
  // reset clears it so reads issued before reset are never captured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue && issue_last;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  // ---- output buffer ----
  sync_fifo #(
    .WIDTH (DDR_W + 1),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe[MEM_LAT-1]),
    .push_data ({last_pipe[MEM_LAT-1], mem_rd_data}),
    .pop       (ddr_valid && ddr_ready),
    .pop_data  (out_head),
    .full      (unused_out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  // Outputs read zero whenever no beat is presented, including during reset.
  assign ddr_valid = !out_empty;
  assign ddr_data  = ddr_valid ? out_head[DDR_W-1:0] : '0;
  assign ddr_last  = ddr_valid && out_head[DDR_W];

endmodule

// File: tb/tb_ddr_rd_responder.sv
`timescale 1ns/1ps
module tb_ddr_rd_responder;
  import ddr_rd_responder_pkg::*;

  localparam int MEM_LAT   = 2;
  localparam int REQ_DEPTH = 4;
  localparam int OUT_DEPTH = MEM_LAT + 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DDR_ADDR_W-1:0] ddr_addr;
  logic [BURST_W-1:0]    ddr_size;
  logic                  ddr_addr_valid;
  logic                  ddr_addr_ready;
  logic [DDR_W-1:0]      ddr_data;
  logic                  ddr_valid;
  logic                  ddr_ready;
  logic                  ddr_last;
  logic                  mem_rd_en;
  logic [DDR_ADDR_W-1:0] mem_rd_addr;
  logic [DDR_W-1:0]      mem_rd_data;

  always #5 clk = ~clk;

  ddr_rd_responder #(.REQ_DEPTH(REQ_DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .ddr_addr       (ddr_addr),
    .ddr_size       (ddr_size),
    .ddr_addr_valid (ddr_addr_valid),
    .ddr_addr_ready (ddr_addr_ready),
    .ddr_data       (ddr_data),
    .ddr_valid      (ddr_valid),
    .ddr_ready      (ddr_ready),
    .ddr_last       (ddr_last),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [DDR_W-1:0] mk_data(input logic [DDR_ADDR_W-1:0] a);
    return {a, a ^ 16'h5A3C};
  endfunction

  // Backing memory: answers each read exactly MEM_LAT cycles later.
  logic                  pipe_en   [MEM_LAT];
  logic [DDR_ADDR_W-1:0] pipe_addr [MEM_LAT];
  initial for (int i = 0; i < MEM_LAT; i++) begin pipe_en[i] = 1'b0; pipe_addr[i] = '0; end
  always @(posedge clk) begin
    pipe_en[0]   <= mem_rd_en;
    pipe_addr[0] <= mem_rd_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_en[i]   <= pipe_en[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
    end
  end
  assign mem_rd_data = pipe_en[MEM_LAT-1] ? mk_data(pipe_addr[MEM_LAT-1]) : 32'hBAD0_BAD0;

  typedef struct packed { logic [DDR_ADDR_W-1:0] addr; logic last; } beat_t;
  typedef struct packed { logic [DDR_W-1:0] data; logic last; } got_t;

  beat_t                 exp_beats[$];
  logic [DDR_ADDR_W-1:0] exp_rd[$];
  got_t                  got[$];
  logic [DDR_ADDR_W-1:0] issued[$];
  int total = 0;
  int bad = 0;
  int issued_n = 0;
  int consumed_n = 0;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model + compare process: a request expands into its list of
  // beat addresses; reads and beats must follow that list in order, and the
  // number of words issued but not yet consumed may never exceed OUT_DEPTH.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (mem_rd_en) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_addr", mem_rd_addr, exp_rd.pop_front());
        check("rd_credit", (issued_n - consumed_n + 1) <= OUT_DEPTH, 1);
        issued.push_back(mem_rd_addr);
        issued_n++;
      end
      if (ddr_valid) begin
        if (exp_beats.size() == 0) check("beat_spurious", 1, 0);
        else begin
          check("beat_data", ddr_data, mk_data(exp_beats[0].addr));
          check("beat_last", ddr_last, exp_beats[0].last);
        end
        if (ddr_ready) begin
          got.push_back('{data: ddr_data, last: ddr_last});
          if (exp_beats.size() != 0) void'(exp_beats.pop_front());
          consumed_n++;
        end
      end
      if (ddr_addr_valid && ddr_addr_ready) begin
        for (int b = 0; b < int'(ddr_size); b++) begin
          exp_beats.push_back('{addr: ddr_addr + DDR_ADDR_W'(b), last: (b == int'(ddr_size) - 1)});
          exp_rd.push_back(ddr_addr + DDR_ADDR_W'(b));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ddr_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_req(input logic [DDR_ADDR_W-1:0] a, input logic [BURST_W-1:0] s,
                          input int budget, output bit accepted);
    ddr_addr = a;
    ddr_size = s;
    ddr_addr_valid = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < budget && !accepted; n++) begin
      if (ddr_addr_ready) accepted = 1'b1;
      tick();
    end
    if (accepted) ddr_addr_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_beats.size() != 0 || ddr_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", (exp_beats.size() == 0) && (exp_rd.size() == 0), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_addr_ready", ddr_addr_ready, 0);
    check("rst_valid", ddr_valid, 0);
    check("rst_last", ddr_last, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_data", ddr_data, 0);
    exp_beats.delete();
    exp_rd.delete();
    issued_n = 0;
    consumed_n = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("ready_before_edge", ddr_addr_ready, 0);
    tick();
    check("ready_after_edge", ddr_addr_ready, 1);
  endtask

  initial begin
    bit acc;
    int n;
    int n_acc;
    int snap;
    rst = 1'b0;
    ddr_addr = '0;
    ddr_size = '0;
    ddr_addr_valid = 1'b0;
    ddr_ready = 1'b1;
    #2;
    do_reset();

    // Single burst: latency, order, last marker
    got.delete();
    send_req(16'h0100, 8'd4, 10, acc);
    n = 1;
    while (!ddr_valid && n < 20) begin tick(); n++; end
    check("first_latency", n, MEM_LAT + 3);
    wait_drain(50);
    check("single_count", got.size(), 4);
    check("single_beat0", got[0].data, 32'h0100_5B3C);
    check("single_beat3", got[3].data, 32'h0103_5B3F);
    check("single_last0", got[0].last, 0);
    check("single_last3", got[3].last, 1);

    // Zero-length request is dropped
    got.delete();
    send_req(16'h0020, 8'd0, 10, acc);
    send_req(16'h0040, 8'd1, 10, acc);
    wait_drain(50);
    check("size0_count", got.size(), 1);
    check("size0_data", got[0].data, 32'h0040_5A7C);
    check("size0_last", got[0].last, 1);

    // Backpressure: reads limited by credit, then full drain
    got.delete();
    ddr_ready = 1'b0;
    snap = issued_n;
    send_req(16'h0200, 8'd8, 10, acc);
    repeat (20) tick();
    check("bp_reads", issued_n - snap, OUT_DEPTH);
    check("bp_valid", ddr_valid, 1);
    ddr_ready = 1'b1;
    wait_drain(100);
    check("bp_count", got.size(), 8);
    for (int i = 0; i < 8; i++) check("bp_order", got[i].data[31:16], 16'h0200 + 16'(i));

    // Request FIFO full
    got.delete();
    ddr_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      send_req(16'h1000 + 16'(i * 256), 8'd16, 10, acc);
      if (acc) n_acc++;
    end
    check("full_accepts", n_acc, 5);
    send_req(16'h1500, 8'd16, 6, acc);
    check("full_blocked", acc, 0);
    check("full_ready", ddr_addr_ready, 0);
    ddr_ready = 1'b1;
    send_req(16'h1500, 8'd16, 300, acc);
    check("full_late_accept", acc, 1);
    wait_drain(400);
    check("full_count", got.size(), 96);

    // Address wrap
    issued.delete();
    send_req(16'hFFFE, 8'd4, 10, acc);
    wait_drain(50);
    check("wrap_count", issued.size(), 4);
    check("wrap_a0", issued[0], 16'hFFFE);
    check("wrap_a1", issued[1], 16'hFFFF);
    check("wrap_a2", issued[2], 16'h0000);
    check("wrap_a3", issued[3], 16'h0001);

    // Reset in the middle of a burst
    got.delete();
    send_req(16'h0300, 8'd8, 10, acc);
    n = 0;
    while (got.size() < 2 && n < 40) begin tick(); n++; end
    check("mid_two_beats", got.size(), 2);
    check("mid_beat3_shown", ddr_valid, 1);
    do_reset();
    got.delete();
    repeat (6) tick();
    check("mid_no_stale", got.size(), 0);
    send_req(16'h0400, 8'd3, 10, acc);
    wait_drain(50);
    check("mid_new_count", got.size(), 3);
    check("mid_new_first", got[0].data, 32'h0400_5E3C);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      send_req(16'($urandom), 8'($urandom_range(0, 10)), 300, acc);
      check("rand_accept", acc, 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain(3000);
    rand_ready = 1'b0;
    ddr_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
